// File: rtl/sram_test_pkg.sv
// Shared types and helpers for the SRAM pattern self-test.
// Contents:
//   state_t          - sequencer state encoding
//   TEST_RESULT_*    - codes on the 2-bit test_result bus (also decoded by the LED driver)
//   pat()            - test pattern generator, evaluated at PAT_W bits; callers truncate
package sram_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        RD_SETUP,
        RD_WAIT,
        RD_CHECK,
        DONE
    } state_t;

    localparam logic [1:0] TEST_RESULT_IDLE = 2'b00;
    localparam logic [1:0] TEST_RESULT_PASS = 2'b01;
    localparam logic [1:0] TEST_RESULT_FAIL = 2'b10;

    // Widest address/data the pattern helper supports.
    localparam int unsigned PAT_W = 32;

    // Address XOR seed, inverted on the second pass.
    function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr,
                                             input logic             pass,
                                             input logic [PAT_W-1:0] seed);
        logic [PAT_W-1:0] base;
        base = addr ^ seed;
        return pass ? ~base : base;
    endfunction

endpackage

// File: rtl/sram_access_timer.sv
// Strobe-width down-counter shared by the write and read strobes.
// Ports:
//   sysClock  in   clock
//   reset     in   synchronous active-high reset
//   load      in   restart the count; the strobe starts on the following cycle
//   done_c    out  high during the last cycle of the strobe (combinational decode)
module sram_access_timer #(
    parameter int unsigned CYCLES = 2
) (
    input  logic sysClock,
    input  logic reset,
    input  logic load,
    output logic done_c
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] count_q;

    // Loaded with CYCLES-1 so done_c rises exactly CYCLES cycles after the load.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_W'(CYCLES - 1);
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/sram_pattern_tester.sv
// Self-test sequencer for the external framebuffer SRAM. Writes pat(a) to every
// address, reads it all back and compares, then repeats with the inverted pattern.
// Optional feature: define SRAMTEST_CONTINUOUS_EN to loop forever after each pass,
// counting completed passing runs on run_count.
// Ports:
//   sysClock      in   clock
//   reset         in   synchronous active-high reset
//   start         in   one-cycle start pulse, honoured only in IDLE
//   sram_addr     out  SRAM address
//   sram_wdata    out  SRAM write data
//   sram_data_oe  out  1 = drive the SRAM data pads
//   sram_rdata    in   SRAM read data from the pads
//   sram_we_n     out  active-low write strobe
//   sram_oe_n     out  active-low output enable
//   busy          out  test in progress
//   fail_addr     out  address of the first miscompare
//   run_count     out  passing runs (SRAMTEST_CONTINUOUS_EN only)
//   test_result   out  00 idle/running, 01 pass, 10 fail
module sram_pattern_tester
    import sram_test_pkg::*;
#(
    parameter int unsigned ADDR_W        = 18,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [15:0] SEED          = 16'hA5C3
) (
    input  logic              sysClock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_data_oe,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic              busy,
    output logic [ADDR_W-1:0] fail_addr,
`ifdef SRAMTEST_CONTINUOUS_EN
    output logic [31:0]       run_count,
`endif
    output logic [1:0]        test_result
);

    localparam logic [DATA_W-1:0] SEED_D = DATA_W'(SEED);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [1:0]        result_q, result_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              data_oe_q, data_oe_d;
    logic              timer_load_c;
    logic              timer_done_c;
    logic              last_addr_c;
    logic [DATA_W-1:0] expect_c;
`ifdef SRAMTEST_CONTINUOUS_EN
    logic [31:0]       run_count_q, run_count_d;
`endif

    sram_access_timer #(
        .CYCLES (ACCESS_CYCLES)
    ) u_timer (
        .sysClock (sysClock),
        .reset    (reset),
        .load     (timer_load_c),
        .done_c   (timer_done_c)
    );

    assign last_addr_c = (addr_q == '1);
    assign expect_c    = DATA_W'(pat(PAT_W'(addr_q), pass_q, PAT_W'(SEED_D)));

    // State register and all registered outputs.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            result_q    <= TEST_RESULT_IDLE;
            busy_q      <= 1'b0;
            rdata_q     <= '0;
            wdata_q     <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
`ifdef SRAMTEST_CONTINUOUS_EN
            run_count_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            rdata_q     <= rdata_d;
            wdata_q     <= wdata_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            data_oe_q   <= data_oe_d;
`ifdef SRAMTEST_CONTINUOUS_EN
            run_count_q <= run_count_d;
`endif
        end
    end

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        result_d     = result_q;
        busy_d       = busy_q;
        rdata_d      = rdata_q;
        timer_load_c = 1'b0;
`ifdef SRAMTEST_CONTINUOUS_EN
        run_count_d  = run_count_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = WR_SETUP;
                    busy_d   = 1'b1;
                    result_d = TEST_RESULT_IDLE;
                    addr_d   = '0;
                    pass_d   = 1'b0;
                end
            end
            WR_SETUP: begin
                timer_load_c = 1'b1;
                state_d      = WR_PULSE;
            end
            WR_PULSE: begin
                if (timer_done_c) state_d = WR_HOLD;
            end
            WR_HOLD: begin
                if (last_addr_c) begin
                    addr_d  = '0;
                    state_d = RD_SETUP;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = WR_SETUP;
                end
            end
            RD_SETUP: begin
                timer_load_c = 1'b1;
                state_d      = RD_WAIT;
            end
            RD_WAIT: begin
                if (timer_done_c) begin
                    rdata_d = sram_rdata;
                    state_d = RD_CHECK;
                end
            end
            RD_CHECK: begin
                if (rdata_q != expect_c) begin
                    fail_addr_d = addr_q;
                    result_d    = TEST_RESULT_FAIL;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end else if (last_addr_c && !pass_q) begin
                    pass_d  = 1'b1;
                    addr_d  = '0;
                    state_d = WR_SETUP;
                end else if (last_addr_c) begin
                    result_d = TEST_RESULT_PASS;
                    state_d  = DONE;
`ifdef SRAMTEST_CONTINUOUS_EN
                    run_count_d = run_count_q + 32'd1;
`else
                    busy_d = 1'b0;
`endif
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = RD_SETUP;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SRAMTEST_CONTINUOUS_EN
                // A passing run restarts immediately; result stays at PASS.
                if (result_q == TEST_RESULT_PASS) begin
                    state_d = WR_SETUP;
                    pass_d  = 1'b0;
                    addr_d  = '0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the state being entered so they register in step with it.
        we_n_d    = (state_d != WR_PULSE);
        oe_n_d    = (state_d != RD_WAIT);
        data_oe_d = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_HOLD);
        wdata_d   = (state_d == WR_SETUP)
                  ? DATA_W'(pat(PAT_W'(addr_d), pass_d, PAT_W'(SEED_D)))
                  : wdata_q;
    end

    assign sram_addr    = addr_q;
    assign sram_wdata   = wdata_q;
    assign sram_data_oe = data_oe_q;
    assign sram_we_n    = we_n_q;
    assign sram_oe_n    = oe_n_q;
    assign busy         = busy_q;
    assign fail_addr    = fail_addr_q;
    assign test_result  = result_q;
`ifdef SRAMTEST_CONTINUOUS_EN
    assign run_count    = run_count_q;
`endif

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Directed self-checking bench for sram_pattern_tester with a 16x8 behavioural SRAM.
// Configuration: ADDR_W=4, DATA_W=8, ACCESS_CYCLES=2, SEED=16'hA5C3 (0xC3 at 8 bits).
// Run length counts sysClock edges from the edge that samples start, inclusive,
// to the edge after which busy reads low.
module tb_sram_pattern_tester;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    logic              sysClock = 1'b0;
    logic              reset    = 1'b1;
    logic              start    = 1'b0;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_data_oe;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we_n;
    logic              sram_oe_n;
    logic              busy;
    logic [ADDR_W-1:0] fail_addr;
    logic [1:0]        test_result;
`ifdef SRAMTEST_CONTINUOUS_EN
    logic [31:0]       run_count;
`endif

    int n_cmp    = 0;
    int n_err    = 0;
    int bus_viol = 0;
    int fault    = 0;   // 0 ideal, 1 data bit 3 stuck at 0, 2 drop pass-1 write to addr 5

    logic [DATA_W-1:0] mem [16];

    sram_pattern_tester #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .ACCESS_CYCLES (2),
        .SEED          (16'hA5C3)
    ) dut (
        .sysClock     (sysClock),
        .reset        (reset),
        .start        (start),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_data_oe (sram_data_oe),
        .sram_rdata   (sram_rdata),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n),
        .busy         (busy),
        .fail_addr    (fail_addr),
`ifdef SRAMTEST_CONTINUOUS_EN
        .run_count    (run_count),
`endif
        .test_result  (test_result)
    );

    always #5 sysClock = ~sysClock;

    // SRAM model. Pass-1 pattern for address 5 is ~(0x05 ^ 0xC3) = 0x39.
    always @(posedge sysClock) begin
        if (!sram_we_n && !(fault == 2 && sram_addr == 4'd5 && sram_wdata == 8'h39))
            mem[sram_addr] <= sram_wdata;
    end

    assign sram_rdata = (fault == 1) ? (mem[sram_addr] & 8'hF7) : mem[sram_addr];

    // Bus contention monitor.
    always @(negedge sysClock) begin
        if ((sram_data_oe && !sram_oe_n) || (!sram_we_n && !sram_oe_n))
            bus_viol <= bus_viol + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start pulse is sampled by exactly one rising edge; returns just after it.
    task automatic pulse_start();
        @(negedge sysClock);
        start = 1'b1;
        @(negedge sysClock);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int cyc_in, output int cyc_out);
        int cyc;
        cyc = cyc_in;
        while (busy && cyc < 3000) begin
            @(negedge sysClock);
            cyc++;
        end
        check_eq("done_timeout", 32'(busy), 32'd0);
        cyc_out = cyc;
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (3) @(negedge sysClock);
        check_eq("rst_busy",    32'(busy),         32'd0);
        check_eq("rst_we_n",    32'(sram_we_n),    32'd1);
        check_eq("rst_oe_n",    32'(sram_oe_n),    32'd1);
        check_eq("rst_data_oe", 32'(sram_data_oe), 32'd0);
        check_eq("rst_result",  32'(test_result),  32'd0);
        check_eq("rst_addr",    32'(sram_addr),    32'd0);
        check_eq("rst_wdata",   32'(sram_wdata),   32'd0);
        check_eq("rst_fail",    32'(fail_addr),    32'd0);
        reset = 1'b0;

        // Baseline pass with a look at the first write access
        pulse_start();
        check_eq("ws0_busy",    32'(busy),         32'd1);
        check_eq("ws0_addr",    32'(sram_addr),    32'd0);
        check_eq("ws0_wdata",   32'(sram_wdata),   32'hC3);
        check_eq("ws0_data_oe", 32'(sram_data_oe), 32'd1);
        check_eq("ws0_we_n",    32'(sram_we_n),    32'd1);
        @(negedge sysClock);
        check_eq("wp0a_we_n",   32'(sram_we_n),    32'd0);
        @(negedge sysClock);
        check_eq("wp0b_we_n",   32'(sram_we_n),    32'd0);
        @(negedge sysClock);
        check_eq("wh0_we_n",    32'(sram_we_n),    32'd1);
        check_eq("wh0_data_oe", 32'(sram_data_oe), 32'd1);
        @(negedge sysClock);
        check_eq("ws1_addr",    32'(sram_addr),    32'd1);
        check_eq("ws1_wdata",   32'(sram_wdata),   32'hC2);
        wait_idle(5, cyc);
        check_eq("base_cycles", 32'(cyc),          32'd257);
        check_eq("base_result", 32'(test_result),  32'd1);
        @(negedge sysClock);
        check_eq("idle_busy",   32'(busy),         32'd0);
        check_eq("idle_result", 32'(test_result),  32'd1);

        // start while busy at addr 3 must not restart the run
        pulse_start();
        cyc = 1;
        while (sram_addr != 4'd3 && cyc < 200) begin
            @(negedge sysClock);
            cyc++;
        end
        check_eq("reach_addr3", 32'(sram_addr), 32'd3);
        start = 1'b1;
        @(negedge sysClock);
        cyc++;
        start = 1'b0;
        wait_idle(cyc, cyc);
        check_eq("busy_start_cycles", 32'(cyc),         32'd257);
        check_eq("busy_start_result", 32'(test_result), 32'd1);

        // Data bit 3 stuck at 0: first pass-0 word with bit 3 set is addr 8
        fault = 1;
        pulse_start();
        wait_idle(1, cyc);
        check_eq("bit3_result", 32'(test_result), 32'd2);
        check_eq("bit3_fail",   32'(fail_addr),   32'd8);
        check_eq("bit3_cycles", 32'(cyc),         32'd101);

        // Pass-1 write to addr 5 dropped
        fault = 2;
        pulse_start();
        wait_idle(1, cyc);
        check_eq("a5_result", 32'(test_result), 32'd2);
        check_eq("a5_fail",   32'(fail_addr),   32'd5);
        check_eq("a5_cycles", 32'(cyc),         32'd217);

        // Reset during the write strobe at addr 7
        fault = 0;
        pulse_start();
        cyc = 1;
        while (!(sram_addr == 4'd7 && !sram_we_n) && cyc < 200) begin
            @(negedge sysClock);
            cyc++;
        end
        check_eq("reach_wp7", 32'(sram_we_n), 32'd0);
        reset = 1'b1;
        @(negedge sysClock);
        check_eq("abort_we_n",    32'(sram_we_n),    32'd1);
        check_eq("abort_data_oe", 32'(sram_data_oe), 32'd0);
        check_eq("abort_busy",    32'(busy),         32'd0);
        check_eq("abort_result",  32'(test_result),  32'd0);
        check_eq("abort_addr",    32'(sram_addr),    32'd0);
        reset = 1'b0;
        pulse_start();
        wait_idle(1, cyc);
        check_eq("fresh_cycles", 32'(cyc),         32'd257);
        check_eq("fresh_result", 32'(test_result), 32'd1);

        check_eq("bus_conflicts", 32'(bus_viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
